bus_router: RTL and testbench

BUS_ROUTER -- requirements
Module: bus_router

---
 rtl/bus_router.sv | 185 ++++++++++++++++++
 tb/tb_bus_router.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_router.sv
// rtl/bus_router.sv - single-master to multi-slave address router with timeout and one-entry pending buffer
module bus_router #(
    parameter int                   NSLV     = 5,
    parameter logic [NSLV*32-1:0]   SLV_BASE = '0,
    parameter logic [NSLV*32-1:0]   SLV_TOP  = '0,
    parameter logic [NSLV-1:0]      REBASE   = '1,
    parameter int                   TIMEOUT  = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mst_valid,
    input  logic                mst_instr,
    input  logic [31:0]         mst_addr,
    input  logic [31:0]         mst_wdata,
    input  logic [3:0]          mst_wstrb,
    output logic [31:0]         mst_rdata,
    output logic                mst_ready,
    output logic                mst_error,
    output logic                mst_busy,
    output logic                mst_ovf,
    output logic [NSLV-1:0]     slv_valid,
    output logic                slv_instr,
    output logic [31:0]         slv_addr,
    output logic [31:0]         slv_wdata,
    output logic [3:0]          slv_wstrb,
    input  logic [NSLV*32-1:0]  slv_rdata,
    input  logic [NSLV-1:0]     slv_ready
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state, state_nxt;
    logic              pend_v;
    logic              pend_instr;
    logic [31:0]       pend_addr;
    logic [31:0]       pend_wdata;
    logic [3:0]        pend_wstrb;
    logic [NSLV-1:0]   sel_oh;
    logic [31:0]       to_cnt;

    logic              req_go;
    logic              req_instr;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              hit;
    logic [NSLV-1:0]   hit_oh;
    logic [31:0]       hit_base;
    logic              sel_ready;
    logic [31:0]       sel_rdata;
    logic              timeout_hit;

    // Request source: a buffered request always goes ahead of a new pulse
    always_comb begin
        req_go    = pend_v | mst_valid;
        req_instr = pend_v ? pend_instr : mst_instr;
        req_addr  = pend_v ? pend_addr  : mst_addr;
        req_wdata = pend_v ? pend_wdata : mst_wdata;
        req_wstrb = pend_v ? pend_wstrb : mst_wstrb;
    end

    // Address decode; scanning downwards lets the lowest matching index win
    always_comb begin
        hit      = 1'b0;
        hit_oh   = '0;
        hit_base = 32'h0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (req_addr >= SLV_BASE[32*i +: 32] && req_addr < SLV_TOP[32*i +: 32]) begin
                hit       = 1'b1;
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit_base  = REBASE[i] ? SLV_BASE[32*i +: 32] : 32'h0;
            end
        end
    end

    // Only the slave that owns the outstanding request may complete it
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = 32'h0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_oh[i]) begin
                sel_ready = sel_ready | slv_ready[i];
                sel_rdata = sel_rdata | slv_rdata[32*i +: 32];
            end
        end
        timeout_hit = (TIMEOUT > 0) && (to_cnt == TO_LAST);
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_go && hit)            state_nxt = S_WAIT;
            S_WAIT: if (sel_ready || timeout_hit) state_nxt = S_IDLE;
            default:                              state_nxt = S_IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        mst_busy = (state == S_WAIT);
    end

    // Request issue, response return and timeout counting
    always_ff @(posedge clock) begin
        if (!reset) begin
            slv_valid <= '0;
            slv_instr <= 1'b0;
            slv_addr  <= 32'h0;
            slv_wdata <= 32'h0;
            slv_wstrb <= 4'h0;
            sel_oh    <= '0;
            to_cnt    <= 32'h0;
            mst_ready <= 1'b0;
            mst_error <= 1'b0;
            mst_rdata <= 32'h0;
        end else begin
            slv_valid <= '0;
            mst_ready <= 1'b0;
            mst_error <= 1'b0;
            mst_rdata <= 32'h0;
            if (state == S_IDLE) begin
                if (req_go) begin
                    if (hit) begin
                        slv_valid <= hit_oh;
                        sel_oh    <= hit_oh;
                        slv_instr <= req_instr;
                        slv_addr  <= req_addr - hit_base;
                        slv_wdata <= req_wdata;
                        slv_wstrb <= req_wstrb;
                        to_cnt    <= 32'h0;
                    end else begin
                        mst_ready <= 1'b1;
                        mst_error <= 1'b1;
                    end
                end
            end else begin
                if (sel_ready) begin
                    mst_ready <= 1'b1;
                    mst_rdata <= sel_rdata;
                end else if (timeout_hit) begin
                    mst_ready <= 1'b1;
                    mst_error <= 1'b1;
                end else if (TIMEOUT > 0 && to_cnt != 32'hFFFF_FFFF) begin
                    to_cnt <= to_cnt + 32'h1;
                end
            end
        end
    end

    // One-entry pending buffer and sticky overflow flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_v     <= 1'b0;
            pend_instr <= 1'b0;
            pend_addr  <= 32'h0;
            pend_wdata <= 32'h0;
            pend_wstrb <= 4'h0;
            mst_ovf    <= 1'b0;
        end else begin
            if (state == S_IDLE && pend_v) pend_v <= 1'b0;
            if (mst_valid) begin
                if ((state == S_IDLE && pend_v) || (state == S_WAIT && !pend_v)) begin
                    pend_v     <= 1'b1;
                    pend_instr <= mst_instr;
                    pend_addr  <= mst_addr;
                    pend_wdata <= mst_wdata;
                    pend_wstrb <= mst_wstrb;
                end else if (state == S_WAIT) begin
                    mst_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_router.sv
// tb/tb_bus_router.sv - directed scoreboard bench for bus_router
module tb_bus_router;

    localparam int NSLV = 3;
    localparam logic [NSLV*32-1:0] BASE = {32'h1800_0000, 32'h8000_0000, 32'h1000_0000};
    localparam logic [NSLV*32-1:0] TOP  = {32'h3000_0000, 32'h8010_0000, 32'h2000_0000};

    logic                clock;
    logic                reset;
    logic                mst_valid;
    logic                mst_instr;
    logic [31:0]         mst_addr;
    logic [31:0]         mst_wdata;
    logic [3:0]          mst_wstrb;
    logic [31:0]         mst_rdata;
    logic                mst_ready;
    logic                mst_error;
    logic                mst_busy;
    logic                mst_ovf;
    logic [NSLV-1:0]     slv_valid;
    logic                slv_instr;
    logic [31:0]         slv_addr;
    logic [31:0]         slv_wdata;
    logic [3:0]          slv_wstrb;
    logic [NSLV*32-1:0]  slv_rdata;
    logic [NSLV-1:0]     slv_ready;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic [71:0] fields;
    } slv_t;

    rsp_t rsp_q[$];
    slv_t slv_q[$];
    int   cyc;
    int   checks;
    int   errors;

    bus_router #(
        .NSLV     (NSLV),
        .SLV_BASE (BASE),
        .SLV_TOP  (TOP),
        .REBASE   (3'b110),
        .TIMEOUT  (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mst_valid (mst_valid),
        .mst_instr (mst_instr),
        .mst_addr  (mst_addr),
        .mst_wdata (mst_wdata),
        .mst_wstrb (mst_wstrb),
        .mst_rdata (mst_rdata),
        .mst_ready (mst_ready),
        .mst_error (mst_error),
        .mst_busy  (mst_busy),
        .mst_ovf   (mst_ovf),
        .slv_valid (slv_valid),
        .slv_instr (slv_instr),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_wstrb (slv_wstrb),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_rsp(input int c, input logic err, input logic [31:0] data);
        rsp_t e;
        e.cyc  = c;
        e.err  = err;
        e.data = data;
        rsp_q.push_back(e);
    endtask

    task automatic exp_slv(input int c, input logic [2:0] oh, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb, input logic instr);
        slv_t e;
        e.cyc    = c;
        e.fields = {oh, addr, wdata, wstrb, instr};
        slv_q.push_back(e);
    endtask

    task automatic req(input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, input logic instr);
        mst_valid = 1'b1;
        mst_addr  = addr;
        mst_wstrb = wstrb;
        mst_wdata = wdata;
        mst_instr = instr;
    endtask

    // One clock: sample just after the edge, score outputs, then drop pulse inputs
    task automatic tick();
        rsp_t r;
        slv_t s;
        @(posedge clock);
        cyc++;
        #1;
        while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
            chk("rsp_missing_at", 128'(cyc), 128'(rsp_q[0].cyc));
            void'(rsp_q.pop_front());
        end
        while (slv_q.size() > 0 && slv_q[0].cyc < cyc) begin
            chk("slv_missing_at", 128'(cyc), 128'(slv_q[0].cyc));
            void'(slv_q.pop_front());
        end
        if (mst_ready) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 128'(mst_ready), 128'(0));
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_cycle", 128'(cyc), 128'(r.cyc));
                chk("rsp_error", 128'(mst_error), 128'(r.err));
                chk("rsp_rdata", 128'(mst_rdata), 128'(r.data));
            end
        end
        if (slv_valid != '0) begin
            if (slv_q.size() == 0) begin
                chk("slv_unexpected", 128'(slv_valid), 128'(0));
            end else begin
                s = slv_q.pop_front();
                chk("slv_cycle", 128'(cyc), 128'(s.cyc));
                chk("slv_fields", 128'({slv_valid, slv_addr, slv_wdata, slv_wstrb, slv_instr}), 128'(s.fields));
            end
        end
        mst_valid = 1'b0;
        slv_ready = '0;
    endtask

    initial begin
        int e;
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        mst_valid = 1'b0;
        mst_instr = 1'b0;
        mst_addr  = 32'h0;
        mst_wdata = 32'h0;
        mst_wstrb = 4'h0;
        slv_rdata = '0;
        slv_ready = '0;
        tick();
        tick();
        chk("reset_outputs", 128'({mst_rdata, mst_ready, mst_error, mst_busy, mst_ovf, slv_valid,
                                   slv_instr, slv_addr, slv_wdata, slv_wstrb}), 128'(0));
        reset = 1'b1;
        tick();

        // Rebased read on slave 1, response two cycles after slv_valid
        req(32'h8000_0010, 4'h0, 32'h0, 1'b1);
        exp_slv(cyc + 1, 3'b010, 32'h0000_0010, 32'h0, 4'h0, 1'b1);
        tick();
        chk("busy_in_wait", 128'(mst_busy), 128'(1));
        tick();
        slv_rdata[63:32] = 32'hDEAD_BEEF;
        slv_ready = 3'b010;
        exp_rsp(cyc + 1, 1'b0, 32'hDEAD_BEEF);
        tick();
        chk("busy_after_rsp", 128'(mst_busy), 128'(0));
        tick();

        // Unmapped address
        req(32'h0000_0004, 4'h0, 32'h0, 1'b0);
        exp_rsp(cyc + 1, 1'b1, 32'h0);
        tick();
        chk("busy_unmapped", 128'(mst_busy), 128'(0));
        tick();

        // Timeout eight WAIT cycles after slv_valid, late slv_ready ignored
        req(32'h8000_0020, 4'h0, 32'h0, 1'b0);
        e = cyc + 1;
        exp_slv(e, 3'b010, 32'h0000_0020, 32'h0, 4'h0, 1'b0);
        exp_rsp(e + 8, 1'b1, 32'h0);
        tick();
        repeat (7) tick();
        chk("busy_before_timeout", 128'(mst_busy), 128'(1));
        tick();
        slv_ready = 3'b010;
        tick();
        tick();

        // slv_ready in the last timeout cycle wins
        req(32'h8000_0030, 4'h0, 32'h0, 1'b0);
        e = cyc + 1;
        exp_slv(e, 3'b010, 32'h0000_0030, 32'h0, 4'h0, 1'b0);
        tick();
        repeat (7) tick();
        slv_rdata[63:32] = 32'h1234_5678;
        slv_ready = 3'b010;
        exp_rsp(e + 8, 1'b0, 32'h1234_5678);
        tick();
        tick();

        // Three back-to-back pulses: second buffered, third dropped
        chk("ovf_clear", 128'(mst_ovf), 128'(0));
        req(32'h8000_0100, 4'h0, 32'h0, 1'b0);
        exp_slv(cyc + 1, 3'b010, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
        tick();
        req(32'h2800_0040, 4'hF, 32'hCAFE_F00D, 1'b0);
        tick();
        req(32'h1000_0000, 4'h0, 32'h0, 1'b0);
        tick();
        chk("ovf_set", 128'(mst_ovf), 128'(1));
        slv_rdata[63:32] = 32'h1111_1111;
        slv_ready = 3'b010;
        exp_rsp(cyc + 1, 1'b0, 32'h1111_1111);
        exp_slv(cyc + 2, 3'b100, 32'h1000_0040, 32'hCAFE_F00D, 4'hF, 1'b0);
        tick();
        tick();
        slv_ready = 3'b010;
        tick();
        slv_rdata[95:64] = 32'h2222_2222;
        slv_ready = 3'b100;
        exp_rsp(cyc + 1, 1'b0, 32'h2222_2222);
        tick();
        tick();
        tick();

        // Overlapping ranges: slave 0 wins and is not rebased
        req(32'h1800_0040, 4'h3, 32'hA5A5_0001, 1'b1);
        exp_slv(cyc + 1, 3'b001, 32'h1800_0040, 32'hA5A5_0001, 4'h3, 1'b1);
        tick();
        slv_rdata[31:0] = 32'h3333_3333;
        slv_ready = 3'b101;
        exp_rsp(cyc + 1, 1'b0, 32'h3333_3333);
        tick();
        tick();

        // Reset in WAIT with a pending entry
        req(32'h8000_0200, 4'h0, 32'h0, 1'b0);
        exp_slv(cyc + 1, 3'b010, 32'h0000_0200, 32'h0, 4'h0, 1'b0);
        tick();
        req(32'h8000_0300, 4'h0, 32'h0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("midwait_reset_outputs", 128'({mst_rdata, mst_ready, mst_error, mst_busy, mst_ovf, slv_valid,
                                           slv_instr, slv_addr, slv_wdata, slv_wstrb}), 128'(0));
        reset = 1'b1;
        tick();
        slv_ready = 3'b010;
        tick();
        tick();
        tick();
        req(32'h8000_0400, 4'h0, 32'h0, 1'b0);
        exp_slv(cyc + 1, 3'b010, 32'h0000_0400, 32'h0, 4'h0, 1'b0);
        tick();
        slv_rdata[63:32] = 32'h4444_4444;
        slv_ready = 3'b010;
        exp_rsp(cyc + 1, 1'b0, 32'h4444_4444);
        tick();
        tick();

        chk("rsp_queue_drained", 128'(rsp_q.size()), 128'(0));
        chk("slv_queue_drained", 128'(slv_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
